// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter.
// Accepts one byte per i_TX_DV strobe while idle, then shifts it out on
// o_TX_Serial as start bit, eight data bits LSB first, and stop bit. Each
// bit lasts CLKS_PER_BIT system clocks. Every output comes straight from a
// flop, so there is no combinational path from the inputs to the pin.
module uart_tx #(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       byte_q,    byte_d;
  logic             serial_q,  serial_d;
  logic             active_q,  active_d;
  logic             done_q,    done_d;

  logic             bit_end;
  logic [2:0]       next_idx;

  assign bit_end  = (clk_cnt_q == CNT_LAST);
  assign next_idx = bit_idx_q + 3'd1;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d  = 1'b1;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = 3'd0;
        if (i_TX_DV) begin
          // The start bit goes onto the line on the accepting edge itself.
          byte_d   = i_TX_Byte;
          state_d  = S_START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          serial_d  = byte_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            bit_idx_d = next_idx;
            serial_d  = byte_q[next_idx];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          // Done rises and Active falls together as the stop bit ends.
          clk_cnt_d = '0;
          done_d    = 1'b1;
          active_d  = 1'b0;
          state_d   = S_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        // One settling clock so that Done stays a single-cycle pulse and DV is ignored.
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line high.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      byte_q    <= 8'd0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two instances share the clock and reset: index 0 runs at the default 416
// clocks per bit, index 1 at 2 clocks per bit for fast randomized frames.
// Expected line levels come from a frame model: bit j of {1, byte, 0} is
// held for CPB clocks starting one clock after the accepting edge.
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      dv_i = 2'b00;
  logic [1:0][7:0] byte_i = '0;
  logic [1:0]      act_o;
  logic [1:0]      ser_o;
  logic [1:0]      done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(416)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (dv_i[0]),
    .i_TX_Byte  (byte_i[0]),
    .o_TX_Active(act_o[0]),
    .o_TX_Serial(ser_o[0]),
    .o_TX_Done  (done_o[0])
  );

  uart_tx #(.CLKS_PER_BIT(2)) dut_small (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_TX_DV    (dv_i[1]),
    .i_TX_Byte  (byte_i[1]),
    .o_TX_Active(act_o[1]),
    .o_TX_Serial(ser_o[1]),
    .o_TX_Done  (done_o[1])
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one byte on instance sm and check every clock of the frame,
  // the Done pulse and the cleanup clock. Optionally strobe DV with
  // another byte at frame cycle inject_at (which must be ignored).
  // With hold set, DV stays high throughout and on return.
  task automatic run_frame(input int sm, input logic [7:0] b, input bit hold,
                           input int inject_at, input logic [7:0] noise);
    int cpb;
    logic [9:0] fr;
    int bad_s, bad_a, bad_d, c;
    cpb = (sm == 1) ? 2 : 416;
    fr  = {1'b1, b, 1'b0};
    dv_i[sm]   = 1'b1;
    byte_i[sm] = b;
    tick();
    for (int j = 0; j < 10; j++) begin
      bad_s = 0; bad_a = 0; bad_d = 0;
      for (int k = 0; k < cpb; k++) begin
        c = j * cpb + k;
        if (ser_o[sm] !== fr[j]) bad_s++;
        if (act_o[sm] !== 1'b1) bad_a++;
        if (done_o[sm] !== 1'b0) bad_d++;
        if (c == inject_at) begin
          dv_i[sm]   = 1'b1;
          byte_i[sm] = noise;
        end else if (!hold) begin
          dv_i[sm] = 1'b0;
        end
        tick();
      end
      checks++;
      if (bad_s !== 0) begin
        errors++;
        $display("FAIL frame_bit dut%0d byte=%02h bit%0d: %0d of %0d clocks differ from required level %0b",
                 sm, b, j, bad_s, cpb, fr[j]);
      end
      checks++;
      if (bad_a !== 0) begin
        errors++;
        $display("FAIL frame_active dut%0d byte=%02h bit%0d: active low on %0d clocks, required 0",
                 sm, b, j, bad_a);
      end
      checks++;
      if (bad_d !== 0) begin
        errors++;
        $display("FAIL frame_done dut%0d byte=%02h bit%0d: done high on %0d clocks, required 0",
                 sm, b, j, bad_d);
      end
    end
    // 10*CPB clocks after the start edge: the Done pulse.
    checks++;
    if (done_o[sm] !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse dut%0d byte=%02h: done=%0b required 1", sm, b, done_o[sm]);
    end
    checks++;
    if (act_o[sm] !== 1'b0) begin
      errors++;
      $display("FAIL done_active dut%0d byte=%02h: active=%0b required 0", sm, b, act_o[sm]);
    end
    checks++;
    if (ser_o[sm] !== 1'b1) begin
      errors++;
      $display("FAIL done_serial dut%0d byte=%02h: serial=%0b required 1", sm, b, ser_o[sm]);
    end
    if (inject_at == 10 * cpb) begin
      dv_i[sm]   = 1'b1;
      byte_i[sm] = noise;
    end else if (!hold) begin
      dv_i[sm] = 1'b0;
    end
    tick();
    // Cleanup clock: Done must already be gone, line still idle.
    checks++;
    if (done_o[sm] !== 1'b0 || ser_o[sm] !== 1'b1 || act_o[sm] !== 1'b0) begin
      errors++;
      $display("FAIL cleanup dut%0d byte=%02h: done/serial/active=%0b%0b%0b required 010",
               sm, b, done_o[sm], ser_o[sm], act_o[sm]);
    end
    if (!hold) dv_i[sm] = 1'b0;
  endtask

  // Observe n clocks with DV low and require an idle line.
  task automatic idle_check(input int sm, input int n, input string tag);
    int bad;
    bad = 0;
    dv_i[sm] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (ser_o[sm] !== 1'b1 || act_o[sm] !== 1'b0 || done_o[sm] !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_%s dut%0d: %0d of %0d clocks not idle, required 0", tag, sm, bad, n);
    end
  endtask

  task automatic test_reset();
    int bad_d, bad_s, bad_a;
    #1 rst = 1'b1;
    tick();
    tick();
    for (int sm = 0; sm < 2; sm++) begin
      checks++;
      if (ser_o[sm] !== 1'b1 || act_o[sm] !== 1'b0 || done_o[sm] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values dut%0d: serial/active/done=%0b%0b%0b required 100",
                 sm, ser_o[sm], act_o[sm], done_o[sm]);
      end
    end
    rst = 1'b0;
    tick();
    // Start a 0x00 frame and abort it in the middle of data bit 2.
    dv_i[0]   = 1'b1;
    byte_i[0] = 8'h00;
    tick();
    dv_i[0] = 1'b0;
    for (int i = 0; i < 3 * 416 + 100; i++) tick();
    checks++;
    if (ser_o[0] !== 1'b0 || act_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: serial/active=%0b%0b required 01", ser_o[0], act_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ser_o[0] !== 1'b1 || act_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: serial/active/done=%0b%0b%0b required 100",
               ser_o[0], act_o[0], done_o[0]);
    end
    tick();
    tick();
    rst = 1'b0;
    bad_d = 0; bad_s = 0; bad_a = 0;
    for (int i = 0; i < 4200; i++) begin
      if (done_o[0] !== 1'b0) bad_d++;
      if (ser_o[0] !== 1'b1) bad_s++;
      if (act_o[0] !== 1'b0) bad_a++;
      tick();
    end
    checks++;
    if (bad_d !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done high on %0d clocks, required 0", bad_d);
    end
    checks++;
    if (bad_s !== 0 || bad_a !== 0) begin
      errors++;
      $display("FAIL abort_idle: serial low %0d / active high %0d clocks, required 0/0", bad_s, bad_a);
    end
  endtask

  task automatic test_single_byte();
    run_frame(0, 8'h41, 1'b0, -1, 8'h00);
    idle_check(0, 10, "after_A");
  endtask

  task automatic test_second_byte();
    run_frame(0, 8'h42, 1'b0, -1, 8'h00);
    idle_check(0, 20, "after_B");
  endtask

  task automatic test_busy_ignore();
    // DV with 0x55 in the middle of data bit 4; line must carry only 0xA5.
    run_frame(0, 8'hA5, 1'b0, 5 * 416 + 7, 8'h55);
    idle_check(0, 50, "after_busy");
  endtask

  task automatic test_held_dv();
    for (int f = 0; f < 3; f++) run_frame(0, 8'hFF, 1'b1, -1, 8'h00);
    dv_i[0] = 1'b0;
    idle_check(0, 10, "after_held");
  endtask

  task automatic test_small_divider();
    int lows;
    logic [19:0] line;
    dv_i[1]   = 1'b1;
    byte_i[1] = 8'h00;
    tick();
    dv_i[1] = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      line[i] = ser_o[1];
      if (ser_o[1] === 1'b0) lows++;
      tick();
    end
    checks++;
    if (lows !== 18) begin
      errors++;
      $display("FAIL small_low_count: %0d low clocks, required 18", lows);
    end
    checks++;
    if (line[19:18] !== 2'b11 || line[17:0] !== 18'd0) begin
      errors++;
      $display("FAIL small_shape: line=%020b required 11000000000000000000", line);
    end
    checks++;
    if (done_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL small_done: done=%0b required 1 at clock 20", done_o[1]);
    end
    tick();
    idle_check(1, 5, "after_small");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, n;
    int inj, gap;
    for (int f = 0; f < 40; f++) begin
      b   = 8'($urandom);
      n   = 8'($urandom);
      inj = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      gap = int'($urandom_range(0, 3));
      run_frame(1, b, 1'b0, inj, n);
      if (gap > 0) idle_check(1, gap, "gap");
    end
    // A couple of random frames at the full bit time too.
    for (int f = 0; f < 2; f++) begin
      b = 8'($urandom);
      n = 8'($urandom);
      run_frame(0, b, 1'b0, int'($urandom_range(0, 4160)), n);
    end
    idle_check(0, 5, "after_random");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_second_byte();
    test_busy_ignore();
    test_held_dv();
    test_small_divider();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
